// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, checks the condition field
// and gates the decoder's PC/register/memory write requests.
module cond_logic #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       En,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       Illegal,
    output logic [3:0] Flags
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       n_f;
    logic       z_f;
    logic       c_f;
    logic       v_f;
    logic       ge;
    logic       cond_ex;
    logic       illegal;
    logic [1:0] flag_write;
    logic       fire;

    assign {n_f, z_f, c_f, v_f} = flags_q;
    assign ge = (n_f == v_f);

    always_comb begin
        cond_ex = 1'b0;
        illegal = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = ge;
            4'b1011: cond_ex = ~ge;
            4'b1100: cond_ex = ~z_f & ge;
            4'b1101: cond_ex = z_f | ~ge;
            4'b1110: cond_ex = 1'b1;
            default: begin
                cond_ex = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

    // A stalled or failed instruction has no architectural side effect.
    assign fire       = cond_ex & En;
    assign flag_write = FlagW & {2{fire}};

    always_comb begin
        flags_d = flags_q;
        if (flag_write[1]) flags_d[3:2] = ALUFlags[3:2];
        if (flag_write[0]) flags_d[1:0] = ALUFlags[1:0];
        if (reset)         flags_d      = RESET_FLAGS;
    end

    always_ff @(posedge clk) begin
        flags_q <= flags_d;
    end

    assign PCSrc    = PCS & fire;
    assign RegWrite = RegW & fire & ~NoWrite;
    assign MemWrite = MemW & fire;
    assign CondEx   = cond_ex;
    assign Illegal  = illegal;
    assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: expected outputs are queued on drive
// and popped when the DUT outputs settle, before the next rising edge.
module tb_cond_logic;

    logic       clk = 1'b0;
    logic       reset;
    logic       En;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic       Illegal;
    logic [3:0] Flags;

    typedef struct {
        logic       cond_ex;
        logic       illegal;
        logic       pcsrc;
        logic       regwrite;
        logic       memwrite;
        logic [3:0] flags;
        string      tag;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_flags;
    int         n_tests = 0;
    int         n_fail  = 0;

    cond_logic #(.RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .reset(reset), .En(En), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .Illegal(Illegal), .Flags(Flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Even codes test a base predicate, odd codes its inverse.
    function automatic logic model_pass(input logic [3:0] c,
                                        input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n ^ v) == 1'b0;
            3'd6: base = !z && (n ^ v) == 1'b0;
            default: base = 1'b1;
        endcase
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    task automatic step(input string tag, input logic rst, input logic en,
                        input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input logic pcs,
                        input logic rw, input logic mw, input logic nw);
        exp_t e;
        exp_t g;
        logic pass;
        @(negedge clk);
        reset = rst; En = en; Cond = c; ALUFlags = alu; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
        pass       = model_pass(c, m_flags);
        e.tag      = tag;
        e.cond_ex  = pass;
        e.illegal  = (c == 4'hF);
        e.pcsrc    = pcs && pass && en;
        e.regwrite = rw && pass && en && !nw;
        e.memwrite = mw && pass && en;
        e.flags    = m_flags;
        sb_q.push_back(e);
        if (rst) m_flags = 4'b0000;
        else if (pass && en) begin
            if (fw[1]) m_flags[3:2] = alu[3:2];
            if (fw[0]) m_flags[1:0] = alu[1:0];
        end
        #2;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            g = sb_q.pop_front();
            chk({g.tag, "_condex"}, CondEx, g.cond_ex);
            chk({g.tag, "_illegal"}, Illegal, g.illegal);
            chk({g.tag, "_pcsrc"}, PCSrc, g.pcsrc);
            chk({g.tag, "_regwrite"}, RegWrite, g.regwrite);
            chk({g.tag, "_memwrite"}, MemWrite, g.memwrite);
            chk({g.tag, "_flags"}, Flags, g.flags);
        end
    endtask

    initial begin
        reset = 1'b1; En = 1'b1; Cond = 4'hE; ALUFlags = 4'hF;
        FlagW = 2'b11; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
        m_flags = 4'b0000;
        repeat (2) @(posedge clk);

        step("rst", 1, 1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
        step("eq_fail", 0, 1, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
        step("set_z", 0, 1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
        step("eq_same", 0, 1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0);
        chk("flags_lat", Flags, 4'b0100);

        step("rst2", 1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        step("part", 0, 1, 4'hE, 4'b1011, 2'b10, 0, 0, 0, 0);
        step("part_chk", 0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("part_flags", Flags, 4'b1000);

        step("rst3", 1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        step("fail_se", 0, 1, 4'h0, 4'hF, 2'b11, 1, 1, 1, 0);
        step("fail_hold", 0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("fail_flags", Flags, 4'b0000);

        step("stall", 0, 0, 4'hE, 4'b0110, 2'b11, 0, 0, 1, 0);
        step("resume", 0, 1, 4'hE, 4'b0110, 2'b11, 0, 0, 1, 0);
        step("post", 0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 1);
        chk("resume_flags", Flags, 4'b0110);

        for (int f = 0; f < 16; f++) begin
            step("sw_set", 0, 1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0);
            for (int c = 0; c < 16; c++) begin
                step("sweep", 0, 1'($urandom_range(0, 1)), 4'(c), 4'h0,
                     2'b00, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            end
        end

        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 3) != 0), 4'($urandom),
                 4'($urandom), 2'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        if (sb_q.size() != 0) chk("sb_left", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the instruction decoder in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the stored flags.
- Gates the decoder's PCS/RegW/MemW into the final PCSrc/RegWrite/MemWrite strobes.
- Updates the flags from the ALU, as directed by the decoder's FlagW.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- En  input  1  stage enable; 0 = stall (no side effects, flags held).
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  from decoder: [1] = write N,Z; [0] = write C,V.
- PCS  input  1  from decoder: instruction writes PC (branch or Rd=15).
- RegW  input  1  from decoder: register-file write request.
- MemW  input  1  from decoder: data-memory write request.
- NoWrite  input  1  suppress register write (CMP); tie 0 if unused.
- PCSrc  output  1  select branch/ALU result as next PC.
- RegWrite  output  1  final register-file write enable.
- MemWrite  output  1  final data-memory write enable.
- CondEx  output  1  condition passed for current instruction.
- Illegal  output  1  Cond = 4'b1111 (NV/unsupported) seen this cycle.
- Flags  output  4  current registered {N,Z,C,V}.

Behaviour:
- Only one clock domain (clk); reset is synchronous and active-high; no asynchronous logic.
- Reset: on a rising clk edge with reset=1, Flags <= RESET_FLAGS. Reset has priority over En and FlagW.
- While reset is high, all other outputs remain combinational functions of the inputs and of Flags = RESET_FLAGS.

Flag register:
- Two independently enabled fields: NZ = Flags[3:2], CV = Flags[1:0].
- Update rule:
  - FlagWrite[1] = FlagW[1] & CondEx & En.
  - FlagWrite[0] = FlagW[0] & CondEx & En.
  - On each rising edge, Flags[3:2] <= ALUFlags[3:2] if FlagWrite[1].
  - On each rising edge, Flags[1:0] <= ALUFlags[1:0] if FlagWrite[0].
  - Otherwise each field holds its value.
- CondEx is evaluated from the registered Flags (previous instruction's result), never from ALUFlags of the same cycle.
- A flag-setting instruction's own condition therefore uses old flags. New flags are visible to the next instruction, with one cycle of latency.

Condition evaluation (combinational, with N,Z,C,V = Flags):
- 0000 EQ: Z.
- 0001 NE: !Z.
- 0010 CS: C.
- 0011 CC: !C.
- 0100 MI: N.
- 0101 PL: !N.
- 0110 VS: V.
- 0111 VC: !V.
- 1000 HI: C&!Z.
- 1001 LS: !C|Z.
- 1010 GE: N==V.
- 1011 LT: N!=V.
- 1100 GT: !Z&(N==V).
- 1101 LE: Z|(N!=V).
- 1110 AL: 1.
- 1111: CondEx=0, Illegal=1.
- Illegal=0 for every other code.

Output gating (combinational, zero latency):
- PCSrc = PCS & CondEx & En.
- RegWrite = RegW & CondEx & En & !NoWrite.
- MemWrite = MemW & CondEx & En.
- CondEx and Illegal are reported regardless of En.

Stall (En=0):
- No architectural side effect this cycle: flags held, all three strobes = 0.
- Resuming with En=1 re-evaluates the same Cond against unchanged Flags.

Simultaneous events:
- FlagW=2'b11 with a failing condition: no flag change.
- FlagW=2'b10: only NZ written; CV held even if ALUFlags[1:0] differ.
- X on the decoder outputs for unimplemented ops: if CondEx=0 or En=0, the strobes must resolve to 0.

Test Plan:
- Reset: reset=1 for 1 cycle with ALUFlags=4'b1111, FlagW=2'b11 -> Flags=4'b0000 after the edge. Then Cond=0000 (EQ), PCS=1 -> CondEx=0, PCSrc=0.
- Flag update and latency: Cond=1110, FlagW=2'b11, ALUFlags=4'b0100 -> Flags=4'b0100 one edge later. In that same cycle a Cond=0000, RegW=1 instruction -> RegWrite=0; in the next cycle -> RegWrite=1.
- Partial write: Flags=4'b0000, Cond=1110, FlagW=2'b10, ALUFlags=4'b1011 -> Flags=4'b1000 (CV unchanged).
- Condition sweep: for each of the 16 NZCV values x 16 Cond codes, compare CondEx and Illegal against the table. Cond=1111 -> CondEx=0, Illegal=1 for all flag values.
- Failed-condition side effects: Flags=4'b0000, Cond=0000, PCS=1, RegW=1, MemW=1, FlagW=2'b11, ALUFlags=4'b1111 -> PCSrc=RegWrite=MemWrite=0; Flags stay 4'b0000.
- Stall and NoWrite:
  - En=0, Cond=1110, FlagW=2'b11, MemW=1, ALUFlags=4'b0110 -> MemWrite=0, Flags unchanged; with En=1 on the next cycle -> MemWrite=1, Flags=4'b0110.
  - Cond=1110, RegW=1, NoWrite=1 -> RegWrite=0.
